program_loader: RTL
===================

# program_loader

Boot-time writer for the PPU's instruction memory. It accepts a framed byte stream from a host over a valid/ready handshake and writes the payload bytes into instruction memory through a byte-wide write port. It verifies an XOR checksum and holds the PA_RISC core in reset until a load completes successfully. It sits beside instruction_memory and drives the write side that the fetch stage never uses.

## Interface

Parameters:
- MEM_BYTES, 256, instruction memory size in bytes; matches the 8-bit IAOQ address space.
- ADDR_W, 8, instruction memory address width.
- MAX_WORDS, MEM_BYTES/4 (64), largest legal header word count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  host byte.
- rx_valid  in  1  host byte valid.
- rx_ready  out  1  loader can accept a byte.
- reload  in  1  synchronous request to restart loading; one-cycle pulse or level.
- im_we  out  1  instruction memory byte write enable.
- im_addr  out  ADDR_W  instruction memory byte address.
- im_data  out  8  instruction memory write byte.
- cpu_hold  out  1  high keeps the core in reset.
- load_done  out  1  program loaded and verified.
- load_err  out  1  bad header or checksum mismatch.

## Operation

- **Frame format:** header byte N (word count), then 4N payload bytes, then one checksum byte. The checksum is the XOR of all payload bytes, seeded with 0x00.
- **Accept rule:** a byte is accepted on a rising edge where rx_valid && rx_ready. Only accepted bytes advance state.
- **States:** IDLE, LOAD, CHECK, DONE, ERROR.
- **IDLE:** on an accepted header:
  - N in 1..MAX_WORDS: latch N, clear the byte index and checksum, go to LOAD.
  - N otherwise (0 or >64): go to ERROR.
- **LOAD:** each accepted byte is written to address = byte index (big-endian order; the first byte of a word goes to the lowest address, its MSB). The byte is XORed into the checksum and the index increments. The accept of byte index 4N-1 moves the FSM to CHECK.
- **CHECK:** on an accepted byte, go to DONE if it equals the checksum, else ERROR. No memory write occurs.
- **DONE and ERROR:** terminal. Only reload or reset leaves them.
- **Outputs by state:**
  - rx_ready = (state is IDLE, LOAD or CHECK) && !reload.
  - cpu_hold = 1 in every state except DONE.
  - load_done = 1 only in DONE.
  - load_err = 1 only in ERROR.
- **reload:** when high, the FSM enters IDLE on the next edge from any state and clears the index and checksum. reload has priority over a simultaneous rx_valid; that byte is not accepted because rx_ready is forced low.
- **No clearing:** memory is never cleared. Bytes above 4N-1 keep their previous contents.
- **Byte index:** ADDR_W bits wide. The maximum index is 255 at N=64; it never wraps within a legal frame.

## Timing

- **Reset values** (reset low, asynchronous): state IDLE, im_we 0, im_addr 0, im_data 0, cpu_hold 1, load_done 0, load_err 0, index 0, checksum 0. rx_ready is 1 after reset releases, unless reload is high.
- **Write latency:** im_we, im_addr and im_data are registered. im_we is high for exactly the one cycle following each accepted payload byte, and 0 otherwise.
- **Throughput:** one byte per cycle. Back-to-back acceptance is allowed, and rx_valid gaps are tolerated.
- **Status latency:** DONE or ERROR, with their outputs, is visible the cycle after the checksum or header byte is accepted. cpu_hold falls in that same cycle.
- **Reset mid-load:** all outputs return to reset values immediately. A write already presented on the memory port is not guaranteed, and the partial image is abandoned.

## Structure

- **Shared package** (loader_pkg): state encoding constants (IDLE=0, LOAD=1, CHECK=2, DONE=3, ERROR=4; 3 bits) and MAX_WORDS. The top-level and bench reuse these.
- **Single module, no sub-module:** the checksum is an 8-bit register, not its own block.
- **Integration:** the top-level ANDs the core reset with !cpu_hold. The instruction_memory write port is driven only by this block.

## Test plan

- **Good frame:** header 0x02, payload 12 34 56 78 9A BC DE F0, checksum 0x00 → eight im_we pulses at im_addr 0x00..0x07 with the matching data; then load_done=1, cpu_hold=0, rx_ready=0.
- **Bad checksum:** same frame with checksum 0x01 → all eight writes occur; then load_err=1, cpu_hold=1, load_done=0.
- **Bad header:** header 0x00, and separately 0x41 → ERROR the next cycle, no im_we pulse.
- **Backpressure:** good frame with rx_valid toggling every other cycle → identical write sequence, no duplicate or skipped address.
- **Full memory:** header 0x40, bytes k=0x00..0xFF (value = k), checksum 0x00 → last write at im_addr 0xFF, no wrap, load_done=1.
- **Reset and reload:** reset low after 3 payload bytes → reset values; the next frame writes again starting at 0x00. Separately, reload high in DONE with rx_valid=1 → byte not accepted; next cycle IDLE, cpu_hold=1, load_done=0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// frame limits and the header range rule.
package loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_WORDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // A header is usable when it names at least one word and fits in memory.
  function automatic logic header_ok(input logic [BYTE_W-1:0] n, input int max_words);
    return (n != '0) && (int'(n) <= max_words);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream into the loader: valid/ready handshake, one byte per beat.
interface program_loader_if;
  import loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/program_loader.sv
// Boot-time writer for the PPU instruction memory. Consumes a framed byte
// stream (header N, 4N payload bytes, XOR checksum), writes the payload to
// consecutive byte addresses from 0, and keeps the core held in reset until
// a frame has been loaded and its checksum verified.
module program_loader
  import loader_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = MEM_BYTES / 4
) (
  input  logic                clk,
  input  logic                reset,
  program_loader_if.slave     rx,
  input  logic                reload,
  output logic                im_we,
  output logic [ADDR_W-1:0]   im_addr,
  output logic [BYTE_W-1:0]   im_data,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam int NW_W = $clog2(MAX_WORDS + 1);
  localparam int LW   = NW_W + 2;

  state_e              state_q, state_d;
  logic [NW_W-1:0]     nwords_q, nwords_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [BYTE_W-1:0]   im_data_q, im_data_d;

  logic                rx_state;
  logic                accept;
  logic [LW-1:0]       last_idx;

  // reload blocks acceptance so a byte offered alongside it is never consumed.
  assign rx_state    = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign rx.rx_ready = rx_state && !reload;
  assign accept      = rx.rx_valid && rx.rx_ready;

  // Index of the final payload byte, 4N-1; one bit wider than the index so N=MAX_WORDS fits.
  assign last_idx    = {nwords_q, 2'b00} - LW'(1);

  assign cpu_hold    = (state_q != ST_DONE);
  assign load_done   = (state_q == ST_DONE);
  assign load_err    = (state_q == ST_ERROR);

  assign im_we       = im_we_q;
  assign im_addr     = im_addr_q;
  assign im_data     = im_data_q;

  // Next state, frame bookkeeping and the registered memory write request.
  always_comb begin
    state_d   = state_q;
    nwords_d  = nwords_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    im_we_d   = 1'b0;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    if (reload) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      csum_d  = '0;
    end else if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (header_ok(rx.rx_data, MAX_WORDS)) begin
            nwords_d = NW_W'(rx.rx_data);
            idx_d    = '0;
            csum_d   = '0;
            state_d  = ST_LOAD;
          end else begin
            state_d  = ST_ERROR;
          end
        end
        ST_LOAD: begin
          im_we_d   = 1'b1;
          im_addr_d = idx_q;
          im_data_d = rx.rx_data;
          csum_d    = csum_q ^ rx.rx_data;
          idx_d     = idx_q + ADDR_W'(1);
          if (LW'(idx_q) == last_idx) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = (rx.rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end
        default: ;
      endcase
    end
  end

  // State and write-port registers; reset abandons any partial image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      nwords_q  <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      im_we_q   <= 1'b0;
      im_addr_q <= '0;
      im_data_q <= '0;
    end else begin
      state_q   <= state_d;
      nwords_q  <= nwords_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      im_we_q   <= im_we_d;
      im_addr_q <= im_addr_d;
      im_data_q <= im_data_d;
    end
  end

endmodule
